// File: rtl/div_share_arbiter.sv
// ---------------------------------------------------------------------------
// div_share_arbiter
//
// Purpose:
//   Shares a single iterative divider core between N_REQ application
//   front-ends. Requests are arbitrated round-robin and the winner's operands
//   are latched. The core is then sequenced with a start/done handshake, and
//   the result is routed back to the requester that won.
//   A zero divisor is answered directly without using the core. A watchdog
//   answers with a timeout status when the core never returns done, so the
//   requester queues cannot stall behind a hung core.
//
// Parameters:
//   N_REQ       number of requesters (2..8)
//   DATA_WIDTH  operand / result width
//   TIMEOUT     cycles allowed after div_start before giving up on div_done
//
// Ports:
//   clk            single clock
//   rst_n          asynchronous active-low reset
//   req_valid      per-requester operand valid
//   req_ready      one-hot accept, combinational, only in IDLE
//   req_dividend   flat bus, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_divisor    flat bus, same slicing
//   req_signed     per-requester signed-division flag
//   rsp_valid      one-hot registered result valid
//   rsp_ready      per-requester result accept
//   rsp_quotient   shared result quotient
//   rsp_remainder  shared result remainder
//   rsp_status     00 ok, 01 divide-by-zero, 10 timeout
//   div_start      one-cycle start pulse to the core
//   div_dividend   latched dividend to the core
//   div_divisor    latched divisor to the core
//   div_signed     latched signed mode to the core
//   div_done       core result-valid pulse
//   div_quotient   core quotient
//   div_remainder  core remainder
// ---------------------------------------------------------------------------
module div_share_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_dividend,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_divisor,
  input  logic [N_REQ-1:0]              req_signed,
  output logic [N_REQ-1:0]              rsp_valid,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_quotient,
  output logic [DATA_WIDTH-1:0]         rsp_remainder,
  output logic [1:0]                    rsp_status,
  output logic                          div_start,
  output logic [DATA_WIDTH-1:0]         div_dividend,
  output logic [DATA_WIDTH-1:0]         div_divisor,
  output logic                          div_signed,
  input  logic                          div_done,
  input  logic [DATA_WIDTH-1:0]         div_quotient,
  input  logic [DATA_WIDTH-1:0]         div_remainder
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [N_REQ-1:0] ONE_HOT_0  = N_REQ'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [1:0]       ST_OK      = 2'b00;
  localparam logic [1:0]       ST_DIVZERO = 2'b01;
  localparam logic [1:0]       ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        owner;
  logic [CNT_W-1:0]        cnt;

  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;
  logic [DATA_WIDTH-1:0]   sel_dividend;
  logic [DATA_WIDTH-1:0]   sel_divisor;
  logic                    sel_signed;

  // Round-robin search: start just above the last served requester and wrap,
  // so the one served most recently is always considered last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pick out the granted requester's operands from the flat buses with a
  // plain mux, which keeps the slice indices constant.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    sel_signed   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == grant_idx) begin
        sel_dividend = req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
        sel_divisor  = req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
        sel_signed   = req_signed[i];
      end
    end
  end

  // The accept strobe only goes to the granted requester while idle. It is
  // also held low during reset, so every output reads zero while rst_n is low.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Main sequencer. The core-side operands are loaded at acceptance and are
  // held until the response is consumed.
  // cnt counts cycles since the div_start pulse. It is zero while the pulse
  // is high, and it steps to 1 on leaving ISSUE. In WAIT, cnt reaching
  // TIMEOUT therefore means TIMEOUT cycles have passed since the start. A
  // done arriving in that same cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= PTR_W'(N_REQ - 1);
      owner         <= '0;
      cnt           <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_status    <= 2'b00;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_signed    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_start <= 1'b0;
          if (grant_found) begin
            owner <= grant_idx;
            cnt   <= '0;
            if (sel_divisor == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_dividend;
              rsp_status    <= ST_DIVZERO;
              rsp_valid     <= ONE_HOT_0 << grant_idx;
              state         <= RESP;
            end else begin
              div_dividend <= sel_dividend;
              div_divisor  <= sel_divisor;
              div_signed   <= sel_signed;
              div_start    <= 1'b1;
              state        <= ISSUE;
            end
          end
        end

        ISSUE: begin
          div_start <= 1'b0;
          cnt       <= CNT_W'(1);
          state     <= WAIT;
        end

        WAIT: begin
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_status    <= ST_OK;
            rsp_valid     <= ONE_HOT_0 << owner;
            state         <= RESP;
          end else if (cnt == CNT_LIMIT) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= ST_TIMEOUT;
            rsp_valid     <= ONE_HOT_0 << owner;
            state         <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid    <= '0;
            ptr          <= owner;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_signed   <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
